// File: rtl/mc6502_bus_responder.sv
// Target side of the 6502 CPU bus. Low addresses hit a zero-wait on-chip byte RAM. All other
// addresses go to a slow external memory over a req/ack port. External writes are posted
// through a small FIFO. External reads stall the CPU with RDY until the data has arrived.
module mc6502_bus_responder #(
    parameter int unsigned RAM_AW  = 11,
    parameter int unsigned WBUF_AW = 2
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        cen,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_db_w,
    input  logic        cpu_sync,
    output logic [7:0]  cpu_db_r,
    output logic        cpu_rdy,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        err_ovf
);

    localparam int unsigned RamDepth  = 1 << RAM_AW;
    localparam int unsigned WbufDepth = 1 << WBUF_AW;

    typedef enum logic [1:0] {StIdle, StDrain, StReq, StHold} rd_state_e;

    // Address decode.
    logic int_hit;
    logic ext_rd;
    logic wr_cmt;
    assign int_hit = (cpu_ab >> RAM_AW) == 16'd0;
    assign ext_rd  = cpu_rw & ~int_hit;
    assign wr_cmt  = cen & ~cpu_rw & ~int_hit;

    // ---------------------------------------------------------------------------------------
    // On-chip RAM
    // ---------------------------------------------------------------------------------------
    logic [7:0] ram [RamDepth];

    // Internal write commits on the CPU clock enable.
    always_ff @(posedge clk) begin
        if (cen && !cpu_rw && int_hit) begin
            ram[cpu_ab[RAM_AW-1:0]] <= cpu_db_w;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Posted-write FIFO
    // ---------------------------------------------------------------------------------------
    logic [23:0]        wbuf [WbufDepth];
    logic [WBUF_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [WBUF_AW:0]   count_q;
    logic               fifo_full, fifo_empty, push, pop;
    logic               err_ovf_q;

    logic               ext_req_q, ext_we_q;
    logic [15:0]        ext_addr_q;
    logic [7:0]         ext_wdata_q;
    logic               ack;

    assign fifo_full  = count_q == (WBUF_AW + 1)'(WbufDepth);
    assign fifo_empty = count_q == '0;
    assign push       = wr_cmt & ~fifo_full;
    assign ack        = ext_req_q & ext_ack;
    assign pop        = ack & ext_we_q;

    // FIFO storage; a write committed while full is dropped.
    always_ff @(posedge clk) begin
        if (push) begin
            wbuf[wr_ptr_q] <= {cpu_ab, cpu_db_w};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + WBUF_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + WBUF_AW'(1);
            if (push && !pop)      count_q <= count_q + (WBUF_AW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (WBUF_AW + 1)'(1);
            if (wr_cmt && fifo_full) err_ovf_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------------------------
    // External read FSM
    // ---------------------------------------------------------------------------------------
    rd_state_e   state_q, state_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        addr_match;
    logic        issue_rd, issue_wr, rd_capture;
    logic        sync_q;
    logic [7:0]  cpu_db_r_q;

    assign addr_match = cpu_ab == rd_addr_q;
    // Queued writes go first whenever no read owns the port, which keeps read-after-write order.
    assign issue_wr   = ~ext_req_q & ~fifo_empty & (state_q != StReq);

    // Next-state, read issue/capture and the combinational RDY.
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        issue_rd   = 1'b0;
        rd_capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ext_rd) begin
                    state_d   = StDrain;
                    rd_addr_d = cpu_ab;
                end
            end
            StDrain: begin
                if (!ext_rd) begin
                    state_d = StIdle;
                end else if (!addr_match) begin
                    rd_addr_d = cpu_ab;
                end else if (fifo_empty && !ext_req_q) begin
                    issue_rd = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                // The handshake always completes; stale data is dropped and the read restarts.
                if (ack) begin
                    if (ext_rd && addr_match) begin
                        rd_capture = 1'b1;
                        state_d    = StHold;
                    end else if (ext_rd) begin
                        rd_addr_d = cpu_ab;
                        state_d   = StDrain;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                if (!ext_rd) begin
                    state_d = StIdle;
                end else if (!addr_match) begin
                    rd_addr_d = cpu_ab;
                    state_d   = StDrain;
                end else if (cen) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cpu_rdy = 1'b1;
        if (!int_hit) begin
            if (!cpu_rw) cpu_rdy = ~fifo_full;
            else         cpu_rdy = (state_q == StHold) & addr_match;
        end
    end

    // FSM state, latched read address and read-data register.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            sync_q     <= 1'b0;
            cpu_db_r_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            if (state_q == StIdle && ext_rd) sync_q <= cpu_sync;
            if (rd_capture)             cpu_db_r_q <= ext_rdata;
            else if (int_hit && cpu_rw) cpu_db_r_q <= ram[cpu_ab[RAM_AW-1:0]];
        end
    end

    // ---------------------------------------------------------------------------------------
    // External port
    // ---------------------------------------------------------------------------------------

    // One outstanding request; req drops on ack so the port idles for at least one clk.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
        end else if (ack) begin
            ext_req_q <= 1'b0;
        end else if (issue_rd) begin
            ext_req_q  <= 1'b1;
            ext_we_q   <= 1'b0;
            ext_addr_q <= rd_addr_q;
        end else if (issue_wr) begin
            ext_req_q                 <= 1'b1;
            ext_we_q                  <= 1'b1;
            {ext_addr_q, ext_wdata_q} <= wbuf[rd_ptr_q];
        end
    end

    // cpu_sync has no effect on ordering; its latched copy is kept only for debug probing.
    logic unused_sync;
    assign unused_sync = sync_q;

    assign cpu_db_r  = cpu_db_r_q;
    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_mc6502_bus_responder.sv
// Bench for mc6502_bus_responder: a bus-level CPU driver and an external memory slave with
// random ack latency, checked against a flat 64 KiB reference memory and a queue of the
// external writes expected on the port, in CPU order.
module tb_mc6502_bus_responder;

    logic        clk = 1'b0;
    logic        rst_x;
    logic        cen;
    logic [15:0] cpu_ab;
    logic        cpu_rw;
    logic [7:0]  cpu_db_w;
    logic        cpu_sync;
    logic [7:0]  cpu_db_r;
    logic        cpu_rdy;
    logic        ext_req, ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack = 1'b0;
    logic [7:0]  ext_rdata = 8'h00;
    logic        err_ovf;

    mc6502_bus_responder #(.RAM_AW(11), .WBUF_AW(2)) dut (
        .clk       (clk),
        .rst_x     (rst_x),
        .cen       (cen),
        .cpu_ab    (cpu_ab),
        .cpu_rw    (cpu_rw),
        .cpu_db_w  (cpu_db_w),
        .cpu_sync  (cpu_sync),
        .cpu_db_r  (cpu_db_r),
        .cpu_rdy   (cpu_rdy),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  model_mem [65536];  // what the CPU should read back
    logic [7:0]  ext_mem   [65536];  // contents of the external memory itself
    logic [23:0] exp_wq [$];         // external writes expected on the port, in order
    logic [15:0] rd_log [$];         // addresses of read requests seen on the port

    int wait_cnt = -1;
    int lat_min  = 0;
    int lat_max  = 3;
    bit ack_hold = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // External memory slave: acks each request after a random latency.
    always @(negedge clk) begin
        logic [23:0] exp_w;
        ext_ack = 1'b0;
        if (!rst_x) begin
            wait_cnt = -1;
        end else if (ext_req) begin
            if (wait_cnt < 0) begin
                wait_cnt = int'($urandom_range(lat_max, lat_min));
                if (!ext_we) rd_log.push_back(ext_addr);
            end
            if (wait_cnt == 0) begin
                if (!ack_hold) begin
                    ext_ack  = 1'b1;
                    wait_cnt = -1;
                    if (ext_we) begin
                        ext_mem[ext_addr] = ext_wdata;
                        exp_w = (exp_wq.size() > 0) ? exp_wq.pop_front() : 24'hxxxxxx;
                        check_eq("wr_order", {8'h0, ext_addr, ext_wdata}, {8'h0, exp_w});
                    end else begin
                        ext_rdata = ext_mem[ext_addr];
                    end
                end
            end else begin
                wait_cnt--;
            end
        end
    end

    // One CPU bus cycle: one idle clk, then commit on the first clk where RDY is high
    // (or immediately when force_c is set, as a CPU ignoring RDY would).
    task automatic cpu_cycle(input logic [15:0] ab, input logic rw, input logic [7:0] wd,
                             input bit force_c, output logic [7:0] rd, output int stalls,
                             output logic rdy_c);
        bit ok = 1'b0;
        cpu_ab   = ab;
        cpu_rw   = rw;
        cpu_db_w = wd;
        cpu_sync = rw & 1'($urandom_range(1, 0));
        cen      = 1'b0;
        stalls   = 0;
        rd       = 8'h00;
        rdy_c    = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cpu_rdy || force_c) begin
                rdy_c = cpu_rdy;
                rd    = cpu_db_r;
                cen   = 1'b1;
                ok    = 1'b1;
                @(posedge clk);
                #1;
                cen = 1'b0;
                break;
            end
            stalls++;
        end
        check_eq("cycle_done", 32'(ok), 32'd1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] rd;
        int         st;
        logic       rc;
        cpu_cycle(a, 1'b0, d, 1'b0, rd, st, rc);
        model_mem[a] = d;
        if (a >= 16'h0800) exp_wq.push_back({a, d});
    endtask

    task automatic do_read(input logic [15:0] a, input string tag);
        logic [7:0] rd;
        int         st;
        logic       rc;
        cpu_cycle(a, 1'b1, 8'h00, 1'b0, rd, st, rc);
        check_eq(tag, {24'h0, rd}, {24'h0, model_mem[a]});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_wq.size() == 0 && !ext_req) break;
        end
        check_eq("drain", 32'(exp_wq.size()), 32'd0);
    endtask

    task automatic set_ext(input logic [15:0] a, input logic [7:0] d);
        ext_mem[a]   = d;
        model_mem[a] = d;
    endtask

    function automatic logic [15:0] pick_addr();
        int r = int'($urandom_range(9, 0));
        if (r <= 3) return 16'($urandom_range(63, 0));
        if (r == 4) return 16'h07FF;
        if (r == 5) return 16'h0800;
        if (r == 6) return 16'hFFFF;
        if (r == 7) return 16'h8000 + 16'($urandom_range(7, 0));
        return 16'hC000 + 16'($urandom_range(7, 0));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         st;
        logic       rc;
        bit         seen;

        for (int i = 0; i < 65536; i++) begin
            ext_mem[i]   = 8'($urandom);
            model_mem[i] = ext_mem[i];
        end
        rst_x = 1'b0; cen = 1'b0; cpu_ab = 16'hC000; cpu_rw = 1'b1;
        cpu_db_w = 8'h00; cpu_sync = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ext_req", 32'(ext_req), 32'd0);
        check_eq("rst_ext_we", 32'(ext_we), 32'd0);
        check_eq("rst_err_ovf", 32'(err_ovf), 32'd0);
        check_eq("rst_ext_addr", 32'(ext_addr), 32'd0);
        check_eq("rst_ext_wdata", 32'(ext_wdata), 32'd0);
        check_eq("rst_db_r", 32'(cpu_db_r), 32'd0);
        check_eq("rst_rdy_ext_rd", 32'(cpu_rdy), 32'd0);
        cpu_rw = 1'b0;
        #1 check_eq("rst_rdy_ext_wr", 32'(cpu_rdy), 32'd1);
        cpu_ab = 16'h0012; cpu_rw = 1'b1;
        #1 check_eq("rst_rdy_int", 32'(cpu_rdy), 32'd1);
        @(negedge clk);
        rst_x = 1'b1;

        // Internal RAM: zero wait states, write then read back.
        cpu_cycle(16'h0012, 1'b0, 8'h5A, 1'b0, rd, st, rc);
        model_mem[16'h0012] = 8'h5A;
        check_eq("int_wr_stall", 32'(st), 32'd0);
        cpu_cycle(16'h0012, 1'b1, 8'h00, 1'b0, rd, st, rc);
        check_eq("int_rd_data", 32'(rd), 32'h5A);
        check_eq("int_rd_stall", 32'(st), 32'd0);

        // External read with a 5-clk ack.
        set_ext(16'hC000, 8'hA9);
        lat_min = 5; lat_max = 5;
        rd_log.delete();
        cpu_cycle(16'hC000, 1'b1, 8'h00, 1'b0, rd, st, rc);
        check_eq("ext_rd_data", 32'(rd), 32'hA9);
        check_eq("ext_rd_stalled", 32'(st > 5), 32'd1);
        check_eq("ext_rd_reqs", 32'(rd_log.size()), 32'd1);

        // Posted write then read of the same external address.
        set_ext(16'h8000, 8'hEE);
        lat_min = 2; lat_max = 2;
        do_write(16'h8000, 8'h11);
        rd_log.delete();
        do_read(16'h8000, "raw_rd_data");
        check_eq("raw_ext_mem", 32'(ext_mem[16'h8000]), 32'h11);
        check_eq("raw_rd_reqs", 32'(rd_log.size()), 32'd1);

        // Randomized traffic; initialise the internal window first.
        for (int i = 0; i < 64; i++) do_write(16'(i), 8'($urandom));
        do_write(16'h07FF, 8'($urandom));
        lat_min = 0; lat_max = 3;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a = pick_addr();
            if ($urandom_range(1, 0) == 1) do_write(a, 8'($urandom));
            else                           do_read(a, "rand_rd");
        end
        wait_drain();
        check_eq("no_ovf_yet", 32'(err_ovf), 32'd0);

        // FIFO overflow with acks held off; the fifth write is dropped.
        set_ext(16'h9004, 8'h00);
        lat_min = 1; lat_max = 1;
        ack_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cpu_cycle(16'h9000 + 16'(k), 1'b0, 8'h40 + 8'(k), 1'b1, rd, st, rc);
            check_eq("ovf_rdy", 32'(rc), 32'(k < 4));
            if (k < 4) begin
                model_mem[16'h9000 + 16'(k)] = 8'h40 + 8'(k);
                exp_wq.push_back({16'h9000 + 16'(k), 8'h40 + 8'(k)});
            end
        end
        check_eq("ovf_err", 32'(err_ovf), 32'd1);
        ack_hold = 1'b0;
        wait_drain();
        do_read(16'h9003, "ovf_rd_last_kept");
        do_read(16'h9004, "ovf_rd_dropped");
        check_eq("ovf_sticky", 32'(err_ovf), 32'd1);

        // Address change while the read request is outstanding.
        set_ext(16'hC000, 8'h3C);
        set_ext(16'hC001, 8'hC3);
        lat_min = 6; lat_max = 6;
        rd_log.delete();
        cpu_ab = 16'hC000; cpu_rw = 1'b1; cen = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ext_req && !ext_we) begin seen = 1'b1; break; end
        end
        check_eq("chg_req_seen", 32'(seen), 32'd1);
        cpu_ab = 16'hC001;
        cpu_cycle(16'hC001, 1'b1, 8'h00, 1'b0, rd, st, rc);
        check_eq("chg_rd_data", 32'(rd), 32'hC3);
        check_eq("chg_reqs", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() == 2) check_eq("chg_req2_addr", 32'(rd_log[1]), 32'hC001);

        // Reset during an outstanding read request.
        lat_min = 30; lat_max = 30;
        cpu_ab = 16'hC000; cpu_rw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ext_req) begin seen = 1'b1; break; end
        end
        check_eq("rstreq_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #3 rst_x = 1'b0;
        #1;
        check_eq("rstreq_ext_req", 32'(ext_req), 32'd0);
        check_eq("rstreq_ext_we", 32'(ext_we), 32'd0);
        check_eq("rstreq_ext_addr", 32'(ext_addr), 32'd0);
        check_eq("rstreq_db_r", 32'(cpu_db_r), 32'd0);
        check_eq("rstreq_err_ovf", 32'(err_ovf), 32'd0);
        check_eq("rstreq_rdy_ext", 32'(cpu_rdy), 32'd0);
        cpu_ab = 16'h0010;
        #1 check_eq("rstreq_rdy_int", 32'(cpu_rdy), 32'd1);
        @(negedge clk);
        rst_x = 1'b1;
        lat_min = 1; lat_max = 1;
        do_read(16'hC000, "post_rst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
